// File: rtl/panel_loader.sv
// panel_loader: front-panel sequencer that deposits a memory image through sw/btnl/btnd, loads the start PC and runs until the run indicator falls.
// Ports: clk, btnCpuReset (async active-low); start/start_pc begin a load; img_* valid/ready entry stream;
// run_ind CPU running indicator; sw/btnl/btnd panel drive; busy/done status; words_loaded deposit count.
module panel_loader #(
  parameter int SETTLE    = 10,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        start,
  input  logic [11:0] start_pc,
  input  logic        img_valid,
  output logic        img_ready,
  input  logic [11:0] img_addr,
  input  logic [11:0] img_data,
  input  logic        img_last,
  input  logic        run_ind,
  output logic [12:0] sw,
  output logic        btnl,
  output logic        btnd,
  output logic        busy,
  output logic        done,
  output logic [12:0] words_loaded
);
  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] ACCEPT      = 4'd1;
  localparam logic [3:0] A_SET       = 4'd2;
  localparam logic [3:0] A_PRESS     = 4'd3;
  localparam logic [3:0] A_REL       = 4'd4;
  localparam logic [3:0] D_SET       = 4'd5;
  localparam logic [3:0] D_PRESS     = 4'd6;
  localparam logic [3:0] D_REL       = 4'd7;
  localparam logic [3:0] S_SET       = 4'd8;
  localparam logic [3:0] S_PRESS     = 4'd9;
  localparam logic [3:0] S_REL       = 4'd10;
  localparam logic [3:0] RUN_WAIT_HI = 4'd11;
  localparam logic [3:0] RUN_WAIT_LO = 4'd12;
  localparam logic [3:0] DONE        = 4'd13;
  logic [3:0]  state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [11:0] addr_q, addr_d, data_q, data_d, pc_q, pc_d, nxt_q, nxt_d;
  logic        last_q, last_d, nxt_v_q, nxt_v_d;
  logic [12:0] sw_q, sw_d, cnt_q, cnt_d;
  logic        btnl_q, btnl_d, btnd_q, btnd_d, rdy_q, rdy_d, busy_q, busy_d, done_q, done_d;
  logic        run_d, enter, phase_end;
  assign phase_end = tmr_q == 8'(SETTLE - 1);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    pc_d    = pc_q;
    nxt_d   = nxt_q;
    nxt_v_d = nxt_v_q;
    cnt_d   = cnt_q;
    run_d   = sw_q[12];
    case (state_q)
      IDLE, DONE: if (start) begin
        pc_d    = start_pc;
        cnt_d   = '0;
        nxt_v_d = 1'b0;
        state_d = ACCEPT;
      end
      ACCEPT: if (img_valid) begin
        addr_d  = img_addr;
        data_d  = img_data;
        last_d  = img_last;
        // zero words are swallowed without touching the panel; a contiguous
        // entry rides on the PDP8's deposit auto-increment instead of Load PC
        state_d = (SKIP_ZERO && img_data == 12'd0) ? (img_last ? S_SET : ACCEPT) :
                  (!nxt_v_q || img_addr != nxt_q) ? A_SET : D_SET;
      end
      A_SET:   state_d = phase_end ? A_PRESS : A_SET;
      A_PRESS: state_d = phase_end ? A_REL : A_PRESS;
      A_REL:   state_d = phase_end ? D_SET : A_REL;
      D_SET:   state_d = phase_end ? D_PRESS : D_SET;
      D_PRESS: state_d = phase_end ? D_REL : D_PRESS;
      D_REL: if (phase_end) begin
        cnt_d   = cnt_q == 13'd4096 ? cnt_q : cnt_q + 13'd1;
        nxt_d   = addr_q + 12'd1;
        nxt_v_d = 1'b1;
        state_d = last_q ? S_SET : ACCEPT;
      end
      S_SET:   state_d = phase_end ? S_PRESS : S_SET;
      S_PRESS: state_d = phase_end ? S_REL : S_PRESS;
      S_REL: if (phase_end) begin
        run_d   = 1'b1;
        state_d = RUN_WAIT_HI;
      end
      RUN_WAIT_HI: state_d = run_ind ? RUN_WAIT_LO : RUN_WAIT_HI;
      RUN_WAIT_LO: if (!run_ind) begin
        run_d   = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    enter  = state_d != state_q;
    tmr_d  = enter ? 8'd0 : tmr_q + 8'd1;
    // switch data only moves when a *_SET phase is entered
    sw_d   = {run_d, !enter ? sw_q[11:0] :
                     state_d == A_SET ? addr_d :
                     state_d == D_SET ? data_d :
                     state_d == S_SET ? pc_d : sw_q[11:0]};
    btnl_d = state_d == A_PRESS || state_d == S_PRESS;
    btnd_d = state_d == D_PRESS;
    rdy_d  = state_d == ACCEPT;
    busy_d = state_d != IDLE && state_d != DONE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      pc_q    <= '0;
      nxt_q   <= '0;
      nxt_v_q <= 1'b0;
      cnt_q   <= '0;
      sw_q    <= '0;
      btnl_q  <= 1'b0;
      btnd_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      pc_q    <= pc_d;
      nxt_q   <= nxt_d;
      nxt_v_q <= nxt_v_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      btnl_q  <= btnl_d;
      btnd_q  <= btnd_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign sw           = sw_q;
  assign btnl         = btnl_q;
  assign btnd         = btnd_q;
  assign img_ready    = rdy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign words_loaded = cnt_q;
endmodule

// File: doc/panel_loader.md
Name: panel_loader

Overview:
- Synthesizable front-panel sequencer for the PDP8 Top.
- Accepts a stream of (address, data) memory-image entries and deposits each word through the switch and button interface (sw, btnl = Load PC, btnd = Deposit).
- After the image is loaded, it loads the start PC, sets the run switch, and waits for the run indicator to fall.
- It replaces hand-timed testbench stimulus for image loading on emulator and board.

Parameters:
- SETTLE, 10: clock cycles each panel phase is held (switch setup, button press, button release); legal range 1–255.
- SKIP_ZERO, 1: when 1, entries with data 12'o0000 are consumed without a deposit.

Ports:
- clk  in  1  system clock.
- btnCpuReset  in  1  reset; one clock; asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- start_pc  in  12  execution start address; sampled when start is accepted.
- img_valid  in  1  image entry valid.
- img_ready  out  1  entry accepted when img_valid & img_ready.
- img_addr  in  12  entry address.
- img_data  in  12  entry word.
- img_last  in  1  marks the final entry.
- run_ind  in  1  CPU running indicator (led[12]).
- sw  out  13  switch register; bit 12 is Run, bits 11:0 are data/address.
- btnl  out  1  Load PC button.
- btnd  out  1  Deposit button.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE.
- words_loaded  out  13  count of deposits performed.

Behaviour:
- Reset: every output is 0 asynchronously, including buttons released mid-press; state goes to IDLE; next_addr is invalid; the counter is cleared.
- States: IDLE, ACCEPT, A_SET, A_PRESS, A_REL, D_SET, D_PRESS, D_REL, S_SET, S_PRESS, S_REL, RUN_WAIT_HI, RUN_WAIT_LO, DONE.
- Phase timer: each *_SET, *_PRESS and *_REL state lasts exactly SETTLE cycles, then advances.
  - *_SET: sw[11:0] is driven; no button pressed.
  - *_PRESS: the relevant button is 1.
  - *_REL: the button is 0 and sw is held.
- Buttons are never both high. sw[11:0] changes only on entry to a *_SET state.
- IDLE / DONE:
  - On start, capture start_pc, clear words_loaded, invalidate next_addr, go to ACCEPT.
  - done=1 only in DONE. busy=1 in every state except IDLE and DONE.
- ACCEPT:
  - img_ready=1, registered, asserted only in this state.
  - On handshake, capture addr, data and last.
  - If SKIP_ZERO and data==0: if last, go to S_SET; else stay in ACCEPT. No panel activity; next_addr unchanged.
  - Else if next_addr is invalid or addr!=next_addr, go to A_SET (address load path).
  - Else go to D_SET (contiguous path; the PDP8 deposit auto-increments PC).
- Address load path: A_SET (sw[11:0]=addr), A_PRESS (btnl=1), A_REL, then D_SET.
- Deposit path: D_SET (sw[11:0]=data), D_PRESS (btnd=1), D_REL.
  - At the end of D_REL: words_loaded+1, next_addr=addr+1 mod 4096 (7777 wraps to 0000, valid).
  - Then go to S_SET if last, else ACCEPT.
- Start path: S_SET (sw[11:0]=start_pc), S_PRESS (btnl=1), S_REL. At the end of S_REL, set sw[12]=1 and go to RUN_WAIT_HI.
- RUN_WAIT_HI: wait for run_ind=1.
- RUN_WAIT_LO: on run_ind=0, set sw[12]=0 and go to DONE. The rising/falling pair is required; a low level alone never completes.
- Latency:
  - Contiguous entry: 3*SETTLE cycles from handshake to the next img_ready.
  - Non-contiguous entry: 6*SETTLE cycles.
- words_loaded saturates at 4096.
- img_valid deasserted in ACCEPT: wait indefinitely with busy=1.

Test Plan:
- Contiguous run, SETTLE=10: entries (0200,7200),(0201,1205),(0202,7402,last), start_pc=0200.
  - Exactly one btnl pulse before the first deposit and one at start.
  - Three btnd pulses, each 10 cycles wide; words_loaded=3.
  - sw[12]=1 after S_REL.
- Gap: entries (0010,0001),(0020,0002).
  - Two btnl pulses with sw=0010 and then sw=0020 during A_PRESS.
  - Deposit-to-ready spacing is 60 cycles for both entries.
- Zero skip, SKIP_ZERO=1: entries (0100,1234),(0101,0000),(0102,4321,last).
  - Middle entry consumed with no button activity; 0102 triggers Load PC.
  - words_loaded=2.
- Wrap: entries (7777,1111),(0000,2222,last).
  - Second entry takes the contiguous path with no btnl.
  - Memory 7777=1111 and 0000=2222.
- Completion: after start, run_ind rises at cycle N and falls at N+500.
  - done=1 one cycle after the fall; sw[12]=0.
  - A start pulse while busy is ignored.
- Reset mid-press: assert btnCpuReset=0 during D_PRESS.
  - btnd=0 and sw=0 immediately, without waiting for a clock.
  - State IDLE, busy=0, words_loaded=0 after release.
